// File: rtl/level_reconstructor.sv
// Rebuilds a signal level from tick-qualified edge pulses, rejecting edges closer than MIN_GAP ticks.
// Define LEVEL_RECON_CNT_EN to compile in the saturating accepted-edge counter; otherwise o_edge_cnt is 0.
module level_reconstructor #(
    parameter int unsigned MIN_GAP = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_edge,
    input  logic             i_clr_err,
    output logic             o_lvl,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_edge_cnt
);

    localparam int unsigned GAP_W = 8;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        LOW_HOLD  = 2'd1,
        HIGH      = 2'd2,
        HIGH_HOLD = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nxt;
    logic             lvl_nxt;
    logic             busy_nxt;
    logic             err_nxt;

    // Next-state, hold countdown and sticky error; a reject's set wins over a same-cycle clear
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        err_nxt   = o_err;
        if (i_clr_err) begin
            err_nxt = 1'b0;
        end
        if (i_tick) begin
            case (state)
                LOW: begin
                    if (i_edge) begin
                        gap_nxt   = GAP_INIT;
                        state_nxt = (MIN_GAP > 1) ? HIGH_HOLD : HIGH;
                    end
                end
                HIGH: begin
                    if (i_edge) begin
                        gap_nxt   = GAP_INIT;
                        state_nxt = (MIN_GAP > 1) ? LOW_HOLD : LOW;
                    end
                end
                LOW_HOLD, HIGH_HOLD: begin
                    if (i_edge) begin
                        err_nxt = 1'b1;
                    end
                    gap_nxt = gap - GAP_W'(1);
                    if (gap == GAP_W'(1)) begin
                        state_nxt = (state == LOW_HOLD) ? LOW : HIGH;
                    end
                end
                default: state_nxt = LOW;
            endcase
        end
        lvl_nxt  = (state_nxt == HIGH) || (state_nxt == HIGH_HOLD);
        busy_nxt = (state_nxt == LOW_HOLD) || (state_nxt == HIGH_HOLD);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= LOW;
            gap    <= '0;
            o_lvl  <= 1'b0;
            o_busy <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            state  <= state_nxt;
            gap    <= gap_nxt;
            o_lvl  <= lvl_nxt;
            o_busy <= busy_nxt;
            o_err  <= err_nxt;
        end
    end

`ifdef LEVEL_RECON_CNT_EN
    logic             accept;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturating tally of accepted edges
    always_comb begin
        accept  = i_tick && i_edge && ((state == LOW) || (state == HIGH));
        cnt_nxt = o_edge_cnt;
        if (accept && (o_edge_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = o_edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_edge_cnt <= '0;
        end else begin
            o_edge_cnt <= cnt_nxt;
        end
    end
`else
    assign o_edge_cnt = '0;
`endif

endmodule

// File: tb/tb_level_reconstructor.sv
// Self-checking bench for level_reconstructor: tick-distance reference model plus directed literal checks.
// Counter expectations follow LEVEL_RECON_CNT_EN as compiled.
module tb_level_reconstructor;

    localparam int unsigned MIN_GAP = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_tick = 1'b0;
    logic             i_edge = 1'b0;
    logic             i_clr_err = 1'b0;
    logic             o_lvl;
    logic             o_busy;
    logic             o_err;
    logic [CNT_W-1:0] o_edge_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    level_reconstructor #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_edge     (i_edge),
        .i_clr_err  (i_clr_err),
        .o_lvl      (o_lvl),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .o_edge_cnt (o_edge_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef LEVEL_RECON_CNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0;
`endif
    endfunction

    // Reference model: an edge is accepted when at least MIN_GAP ticks separate it from the last accepted one
    int   m_tidx;
    int   m_last;
    bit   m_last_valid;
    bit   m_lvl;
    bit   m_err;
    bit   m_busy;
    int   m_acc;
    bit   m_ready = 1'b0;

    always @(posedge i_clk) begin
        bit rejected;
        rejected = 1'b0;
        if (i_rst) begin
            m_tidx = 0;
            m_last = 0;
            m_last_valid = 1'b0;
            m_lvl = 1'b0;
            m_err = 1'b0;
            m_acc = 0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            if (i_tick) begin
                m_tidx++;
                if (i_edge) begin
                    if (!m_last_valid || (m_tidx - m_last) >= int'(MIN_GAP)) begin
                        m_lvl = ~m_lvl;
                        m_last = m_tidx;
                        m_last_valid = 1'b1;
                        m_acc++;
                    end else begin
                        rejected = 1'b1;
                    end
                end
            end
            if (rejected) m_err = 1'b1;
            else if (i_clr_err) m_err = 1'b0;
        end
        m_busy = m_last_valid && ((m_tidx - m_last) < int'(MIN_GAP) - 1);
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        if (m_ready) begin
            check("lvl", 32'(o_lvl), 32'(m_lvl));
            check("busy", 32'(o_busy), 32'(m_busy));
            check("err", 32'(o_err), 32'(m_err));
            check("edge_cnt", 32'(o_edge_cnt), 32'(exp_cnt(m_acc)));
        end
    end

    task automatic cycle(input logic t, input logic e, input logic c, input logic r);
        i_tick = t;
        i_edge = e;
        i_clr_err = c;
        i_rst = r;
        @(posedge i_clk);
        #1;
    endtask

    // noise: 0 quiet, 1 random edges between ticks, 2 random edges and clears between ticks
    task automatic tick_slot(input logic e, input logic clr_on_tick, input int noise);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0,
                  (noise > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                  (noise > 1) ? 1'($urandom_range(0, 31) == 0) : 1'b0,
                  1'b0);
        end
        cycle(1'b1, e, clr_on_tick, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        check("reset_lvl", 32'(o_lvl), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        check("reset_cnt", 32'(o_edge_cnt), 32'd0);

        // Edges on ticks 2, 7, 12
        for (int i = 1; i <= 12; i++) begin
            tick_slot(i == 2 || i == 7 || i == 12, 1'b0, 0);
            if (i == 2) begin
                check("s1_lvl_t2", 32'(o_lvl), 32'd1);
                check("s1_busy_t2", 32'(o_busy), 32'd1);
            end
            if (i == 5) check("s1_busy_t5", 32'(o_busy), 32'd0);
            if (i == 7) check("s1_lvl_t7", 32'(o_lvl), 32'd0);
        end
        check("s1_lvl", 32'(o_lvl), 32'd1);
        check("s1_cnt", 32'(o_edge_cnt), 32'(exp_cnt(3)));
        check("s1_err", 32'(o_err), 32'd0);

        // Edges on ticks 2 and 5: second rejected, then cleared
        do_reset();
        for (int i = 1; i <= 5; i++) tick_slot(i == 2 || i == 5, 1'b0, 0);
        check("s2_lvl", 32'(o_lvl), 32'd1);
        check("s2_err", 32'(o_err), 32'd1);
        check("s2_cnt", 32'(o_edge_cnt), 32'(exp_cnt(1)));
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("s2_clr", 32'(o_err), 32'd0);

        // Edges on ticks 2 and 6: exactly MIN_GAP apart, both accepted
        do_reset();
        for (int i = 1; i <= 6; i++) tick_slot(i == 2 || i == 6, 1'b0, 0);
        check("s3_lvl", 32'(o_lvl), 32'd0);
        check("s3_cnt", 32'(o_edge_cnt), 32'(exp_cnt(2)));
        check("s3_err", 32'(o_err), 32'd0);

        // Edge pulses without a tick are ignored
        do_reset();
        tick_slot(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) tick_slot(1'b0, 1'b0, 1);
        check("s4_lvl", 32'(o_lvl), 32'd1);
        check("s4_err", 32'(o_err), 32'd0);
        check("s4_cnt", 32'(o_edge_cnt), 32'(exp_cnt(1)));

        // Clear in the same cycle as a rejected edge: set wins
        tick_slot(1'b1, 1'b0, 0);
        tick_slot(1'b1, 1'b1, 0);
        check("s5_err_prio", 32'(o_err), 32'd1);

        // Reset while in HIGH_HOLD
        do_reset();
        tick_slot(1'b0, 1'b0, 0);
        tick_slot(1'b1, 1'b0, 0);
        tick_slot(1'b0, 1'b0, 0);
        check("s6_hold_busy", 32'(o_busy), 32'd1);
        check("s6_hold_lvl", 32'(o_lvl), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("s6_rst_lvl", 32'(o_lvl), 32'd0);
        check("s6_rst_busy", 32'(o_busy), 32'd0);
        check("s6_rst_cnt", 32'(o_edge_cnt), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            tick_slot(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), 2);
        end

        // 300 edges 4 ticks apart: counter saturates
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick_slot(1'b1, 1'b0, 0);
            for (int j = 0; j < 3; j++) tick_slot(1'b0, 1'b0, 0);
        end
        check("s7_sat_cnt", 32'(o_edge_cnt), 32'(exp_cnt(300)));
        check("s7_lvl", 32'(o_lvl), 32'd0);
        check("s7_err", 32'(o_err), 32'd0);

        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
